nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 146 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: walks WIDTH-bit operands through an external 4-bit
// carry-lookahead adder one nibble per cycle, LSB nibble first.
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic [3:0]       cla_a,
   output logic [3:0]       cla_b,
   output logic             cla_cin,
   input  logic [3:0]       cla_s,
   input  logic             cla_cout
);

   localparam int NIB   = WIDTH / 4;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic               r_carry;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_sum;
   logic               r_cout;
   logic               r_ovf;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_acc;

   logic [3:0]         w_a_nib;
   logic [3:0]         w_b_nib;
   logic [WIDTH-1:0]   w_acc_next;
   logic               w_last;

   // Signed overflow: operands agree in sign but the result sign differs.
   function automatic logic f_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return ~(a_msb ^ b_msb) & (a_msb ^ s_msb);
   endfunction

   always_comb begin
      w_a_nib    = 4'd0;
      w_b_nib    = 4'd0;
      w_acc_next = r_acc;
      for (int n = 0; n < NIB; n++) begin
         if (r_idx == IDX_W'(n)) begin
            w_a_nib              = r_a[n*4 +: 4];
            w_b_nib              = r_b[n*4 +: 4];
            w_acc_next[n*4 +: 4] = cla_s;
         end
      end
   end

   assign w_last = (r_idx == IDX_W'(NIB - 1));

   always_comb begin
      cla_a   = 4'd0;
      cla_b   = 4'd0;
      cla_cin = 1'b0;
      if (r_state == S_RUN) begin
         cla_a   = w_a_nib;
         cla_b   = w_b_nib;
         cla_cin = r_carry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_idx      <= '0;
                  r_carry    <= in_cin;
                  r_in_ready <= 1'b0;
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               r_carry <= cla_cout;
               r_idx   <= r_idx + 1'b1;
               if (w_last) begin
                  r_sum       <= w_acc_next;
                  r_cout      <= cla_cout;
                  r_ovf       <= f_ovf(r_a[WIDTH-1], r_b[WIDTH-1], cla_s[3]);
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Operand and partial-sum storage carry no reset; they are only read in RUN.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && in_valid) begin
         r_a <= in_a;
         r_b <= in_b;
      end
      if (r_state == S_RUN) begin
         r_acc <= w_acc_next;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;
   assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16) with a behavioural 4-bit adder on
// the cla_* port and an integer-arithmetic reference model.
module tb_nibble_serial_adder;

   localparam int WIDTH = 16;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              in_valid  = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  in_a      = '0;
   logic [WIDTH-1:0]  in_b      = '0;
   logic              in_cin    = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [WIDTH-1:0]  out_sum;
   logic              out_cout;
   logic              out_ovf;
   logic [3:0]        cla_a;
   logic [3:0]        cla_b;
   logic              cla_cin;
   logic [3:0]        cla_s;
   logic              cla_cout;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .cla_a     (cla_a),
      .cla_b     (cla_b),
      .cla_cin   (cla_cin),
      .cla_s     (cla_s),
      .cla_cout  (cla_cout)
   );

   always #5 clk = ~clk;

   always_comb begin
      {cla_cout, cla_s} = 5'(cla_a) + 5'(cla_b) + 5'(cla_cin);
   end

   function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b, input logic c);
      int s;
      s = int'(a) + int'(b) + int'(c);
      return 17'(s);
   endfunction

   function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b, input logic c);
      int s;
      s = int'($signed(a)) + int'($signed(b)) + int'(c);
      return (s > 32767) || (s < -32768);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c, input bit chk_cin);
      int k;
      int guard;
      logic [16:0] e;
      e = ref_sum(a, b, c);
      guard = 0;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      chk("ready_before_op", 32'(in_ready), 32'd1);
      in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      k = 1;
      while (!out_valid && k < 20) begin
         if (chk_cin) chk("cla_cin_run", 32'(cla_cin), 32'd1);
         tick();
         k++;
      end
      chk("latency", 32'(k), 32'd5);
      chk("sum", 32'(out_sum), 32'(e[15:0]));
      chk("cout", 32'(out_cout), 32'(e[16]));
      chk("ovf", 32'(out_ovf), 32'(ref_ovf(a, b, c)));
      chk("cla_zero_done", 32'({cla_a, cla_b, cla_cin}), 32'd0);
      chk("in_ready_done", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("idle_after_ack", 32'(in_ready), 32'd1);
      chk("ovalid_cleared", 32'(out_valid), 32'd0);
      chk("sum_retained", 32'(out_sum), 32'(e[15:0]));
   endtask

   initial begin
      logic [16:0] q_sum[$];
      logic        q_ovf[$];
      logic [16:0] e;
      logic        eo;
      int          last_acc;
      int          n_acc;
      int          n_done;
      int          guard;

      // Reset state
      tick();
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_cout_ovf", 32'({out_cout, out_ovf}), 32'd0);
      chk("rst_cla", 32'({cla_a, cla_b, cla_cin}), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed cases
      do_op(16'h1234, 16'h4321, 1'b0, 1'b0);
      do_op(16'hFFFF, 16'h0000, 1'b1, 1'b1);
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      do_op(16'h8000, 16'h8000, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      end

      // Back-pressure in DONE
      in_a = 16'h0F0F; in_b = 16'h1111; in_cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum0", 32'(out_sum), 32'h2020);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i % 2 == 0);
         in_a = 16'($urandom);
         tick();
         chk("hold_sum", 32'(out_sum), 32'h2020);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("hold_release_ready", 32'(in_ready), 32'd1);
      chk("hold_release_valid", 32'(out_valid), 32'd0);
      chk("hold_release_sum", 32'(out_sum), 32'h2020);

      // Reset abort at idx=2
      in_a = 16'hABCD; in_b = 16'h1234; in_cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("abort_cla_a_idx2", 32'(cla_a), 32'hB);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_out_sum", 32'(out_sum), 32'd0);
      chk("abort_cout_ovf", 32'({out_cout, out_ovf}), 32'd0);
      chk("abort_cla", 32'({cla_a, cla_b, cla_cin}), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      do_op(16'h0001, 16'h0001, 1'b0, 1'b0);

      // Back-to-back random stream with in_valid and out_ready high
      last_acc = -1;
      n_acc = 0;
      n_done = 0;
      guard = 0;
      in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
      in_valid = 1'b1;
      out_ready = 1'b1;
      while (n_done < 256 && guard < 3000) begin
         if (out_valid) begin
            if (q_sum.size() > 0) begin
               e  = q_sum.pop_front();
               eo = q_ovf.pop_front();
               chk("b2b_sum_cout", 32'({out_cout, out_sum}), 32'(e));
               chk("b2b_ovf", 32'(out_ovf), 32'(eo));
            end else begin
               chk("b2b_unexpected_result", 32'(out_valid), 32'd0);
            end
            n_done++;
         end
         if (in_ready && n_acc < 256) begin
            q_sum.push_back(ref_sum(in_a, in_b, in_cin));
            q_ovf.push_back(ref_ovf(in_a, in_b, in_cin));
            if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'd6);
            last_acc = cyc;
            n_acc++;
         end
         tick();
         guard++;
         if (n_acc >= 256) in_valid = 1'b0;
         in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("b2b_completed", 32'(n_done), 32'd256);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
